fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//    Instruction fetch sequencer. It issues one instruction-memory read at a
//    time, presents each returned word to decode, holds a word while decode
//    is stalled, and follows taken-branch redirects. A response that belongs
//    to a request made before a redirect is thrown away. A HLT in decode
//    parks the sequencer until reset.
//
// Ports:
//    clk            system clock, rising edge
//    rst_n          asynchronous active-low reset
//    stall          decode hazard hold; freezes the fetch stage
//    should_branch  taken-branch pulse from decode
//    branch_addr    redirect target (valid with should_branch)
//    halt           decode holds a HLT instruction
//    imem_valid     memory returns data for the pending request
//    imem_rd        memory read request
//    imem_addr      memory read address
//    f_valid        word presented to decode is live this cycle
//    f_pc           address of the word marked by f_valid (0 otherwise)
//    flush_D        invalidates the instruction currently in decode
//    halted         sequencer is parked in HALT
//    taken_cnt      saturating redirect counter (optional, see below)
//
// Configuration:
//    FETCH_BRANCH_CNT_EN  when defined, adds the taken_cnt output port and
//                         its redirect counter.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        should_branch,
   input  logic [15:0] branch_addr,
   input  logic        halt,
   input  logic        imem_valid,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   output logic        f_valid,
   output logic [15:0] f_pc,
   output logic        flush_D,
   output logic        halted
`ifdef FETCH_BRANCH_CNT_EN
   ,
   output logic [15:0] taken_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      HALT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] fetch_pc_q, fetch_pc_d;
   // Address of the outstanding request. It only differs from fetch_pc
   // while a stale request is being drained after a redirect.
   logic [15:0] req_addr_q, req_addr_d;
   logic [15:0] hold_pc_q, hold_pc_d;
   logic        drop_q, drop_d;
   logic        flush_q, flush_d;
   logic        redirect;
   logic        halt_now;

`ifdef FETCH_BRANCH_CNT_EN
   logic [15:0] taken_cnt_q, taken_cnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      hold_pc_d  = hold_pc_q;
      drop_d     = drop_q;
      flush_d    = 1'b0;
      f_valid    = 1'b0;

      // A branch seen under stall is ignored; decode presents it again.
      redirect = should_branch && !stall && (state_q == FETCH || state_q == HOLD);
      halt_now = halt && !stall && (state_q != HALT);

      case (state_q)
         IDLE: begin
            state_d    = FETCH;
            fetch_pc_d = RESET_VECTOR;
            req_addr_d = RESET_VECTOR;
            drop_d     = 1'b0;
         end
         FETCH: begin
            if (redirect) begin
               fetch_pc_d = branch_addr;
               flush_d    = 1'b1;
               // A word arriving with the redirect is simply discarded; if
               // the old request is still in flight its answer must be
               // drained before the target can be requested.
               if (imem_valid) begin
                  req_addr_d = branch_addr;
                  drop_d     = 1'b0;
               end else begin
                  drop_d     = 1'b1;
               end
            end else if (imem_valid) begin
               if (drop_q) begin
                  drop_d     = 1'b0;
                  req_addr_d = fetch_pc_q;
               end else if (stall) begin
                  hold_pc_d  = req_addr_q;
                  state_d    = HOLD;
               end else begin
                  f_valid    = 1'b1;
                  fetch_pc_d = fetch_pc_q + 16'd1;
                  req_addr_d = fetch_pc_q + 16'd1;
               end
            end
         end
         HOLD: begin
            f_valid = !redirect;
            if (redirect) begin
               state_d    = FETCH;
               fetch_pc_d = branch_addr;
               req_addr_d = branch_addr;
               flush_d    = 1'b1;
            end else if (!stall) begin
               state_d    = FETCH;
               fetch_pc_d = fetch_pc_q + 16'd1;
               req_addr_d = fetch_pc_q + 16'd1;
            end
         end
         HALT: begin
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Halt outranks everything, including a same-cycle redirect.
      if (halt_now) begin
         state_d = HALT;
         flush_d = 1'b0;
         f_valid = 1'b0;
      end

`ifdef FETCH_BRANCH_CNT_EN
      taken_cnt_d = taken_cnt_q;
      if (redirect && !halt_now && taken_cnt_q != 16'hFFFF) begin
         taken_cnt_d = taken_cnt_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_VECTOR;
         req_addr_q  <= RESET_VECTOR;
         hold_pc_q   <= 16'h0000;
         drop_q      <= 1'b0;
         flush_q     <= 1'b0;
`ifdef FETCH_BRANCH_CNT_EN
         taken_cnt_q <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_addr_q  <= req_addr_d;
         hold_pc_q   <= hold_pc_d;
         drop_q      <= drop_d;
         flush_q     <= flush_d;
`ifdef FETCH_BRANCH_CNT_EN
         taken_cnt_q <= taken_cnt_d;
`endif
      end
   end

   assign imem_rd   = (state_q == FETCH);
   assign imem_addr = req_addr_q;
   assign f_pc      = f_valid ? ((state_q == HOLD) ? hold_pc_q : req_addr_q) : 16'h0000;
   assign flush_D   = flush_q;
   assign halted    = (state_q == HALT);

`ifdef FETCH_BRANCH_CNT_EN
   assign taken_cnt = taken_cnt_q;
`endif

endmodule
